// File: rtl/lsu_pkg.sv
// Shared load/store encodings: one-hot access size and the controller state type.
package lsu_pkg;

    // The extension stage decodes mem_len with these same values.
    localparam logic [2:0] LEN_W = 3'b100;
    localparam logic [2:0] LEN_H = 3'b010;
    localparam logic [2:0] LEN_B = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: size decode, alignment check, byte enables,
// store replication and load shift.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  mem_len,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic        illegal,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_shift
);

    logic is_w, is_h, is_b;

    // Multi-hot sizes resolve as word > half > byte.
    assign is_w = |(mem_len & LEN_W);
    assign is_h = ~is_w & |(mem_len & LEN_H);
    assign is_b = ~is_w & ~is_h & |(mem_len & LEN_B);

    assign illegal    = ~(is_w | is_h | is_b);
    assign misaligned = (is_h & offset[0]) | (is_w & (offset != 2'b00));

    always_comb begin
        be        = 4'b0000;
        wdata_rep = 32'h0;
        if (is_w) begin
            be        = 4'b1111;
            wdata_rep = wdata;
        end else if (is_h) begin
            be        = 4'b0011 << {offset[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
        end else if (is_b) begin
            be        = 4'b0001 << offset;
            wdata_rep = {4{wdata[7:0]}};
        end
    end

    // Word accesses are aligned, so a zero-filled shift covers every size.
    assign rdata_shift = mem_rdata >> {offset, 3'b000};

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one core request becomes one word-aligned bus
// transaction; the core is stalled until the response pulse.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  mem_len,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_e      state_q;
    logic [CntW-1:0] wait_cnt_q;

    logic        illegal, misaligned;
    logic [3:0]  be;
    logic [31:0] wdata_rep, rdata_shift;
    logic        timed_out;

    lsu_lane_align u_lane_align (
        .mem_len     (mem_len),
        .offset      (req_addr[1:0]),
        .wdata       (req_wdata),
        .mem_rdata   (dmem_rdata),
        .illegal     (illegal),
        .misaligned  (misaligned),
        .be          (be),
        .wdata_rep   (wdata_rep),
        .rdata_shift (rdata_shift)
    );

    assign stall     = req_valid & ~done;
    assign timed_out = (TIMEOUT != 0) && (wait_cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= 32'h0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= 32'h0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done       <= 1'b0;
                    err        <= 1'b0;
                    wait_cnt_q <= '0;
                    if (req_valid) begin
                        if (illegal || misaligned) begin
                            state_q <= RESP;
                            done    <= 1'b1;
                            err     <= 1'b1;
                            rdata   <= 32'h0;
                        end else begin
                            state_q    <= WAIT;
                            dmem_req   <= 1'b1;
                            dmem_we    <= req_we;
                            dmem_addr  <= {req_addr[31:2], 2'b00};
                            dmem_be    <= be;
                            dmem_wdata <= wdata_rep;
                        end
                    end
                end
                WAIT: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (dmem_ack) begin
                        state_q  <= RESP;
                        dmem_req <= 1'b0;
                        done     <= 1'b1;
                        err      <= 1'b0;
                        rdata    <= dmem_we ? 32'h0 : rdata_shift;
                    end else if (timed_out) begin
                        state_q  <= RESP;
                        dmem_req <= 1'b0;
                        done     <= 1'b1;
                        err      <= 1'b1;
                        rdata    <= 32'h0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CntW'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                    err     <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
